// File: rtl/mux_logic_unit.sv
// Two-stage valid/ready bitwise logic unit whose every result bit is a 2:1 mux selected by a[i].
// Optional multi-beat AND-reduction folds per-beat results into one output beat.
module mux_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_reduce,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op
);

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_reduce;
    logic             s1_last;
    logic             s1_valid;
    logic             s1_adv;
    logic [WIDTH-1:0] s1_result;
    logic [WIDTH-1:0] acc;
    logic             acc_busy;
    logic [WIDTH-1:0] acc_and;

    // Each op only chooses the two mux data inputs; a[i] always drives the select.
    function automatic logic [WIDTH-1:0] mux_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x1;
        logic [WIDTH-1:0] x0;
        logic [WIDTH-1:0] y;
        x1 = b;
        x0 = b;
        y  = '0;
        case (op)
            3'd0: begin x1 = b;  x0 = '0; end
            3'd1: begin x1 = '1; x0 = b;  end
            3'd2: begin x1 = ~b; x0 = b;  end
            3'd3: begin x1 = ~b; x0 = '1; end
            3'd4: begin x1 = '0; x0 = ~b; end
            3'd5: begin x1 = b;  x0 = ~b; end
            3'd6: begin x1 = '0; x0 = '1; end
            default: begin x1 = b; x0 = b; end
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = a[i] ? x1[i] : x0[i];
        end
        return y;
    endfunction

    always_comb begin
        s1_result = mux_op(s1_op, s1_a, s1_b);
        acc_and   = acc_busy ? (acc & s1_result) : s1_result;
        s1_adv    = s1_valid & (~out_valid | out_ready);
        in_ready  = rst_n & (~s1_valid | s1_adv);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_reduce <= 1'b0;
            s1_last   <= 1'b0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            acc_busy  <= 1'b0;
            out_y     <= '0;
            out_op    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_op     <= in_op;
                s1_reduce <= in_reduce;
                s1_last   <= in_last;
                s1_valid  <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (s1_adv) begin
                if (!s1_reduce) begin
                    // A plain beat also aborts any packet still being accumulated.
                    out_y     <= s1_result;
                    out_op    <= s1_op;
                    out_valid <= 1'b1;
                    acc_busy  <= 1'b0;
                end else if (!s1_last) begin
                    acc      <= acc_and;
                    acc_busy <= 1'b1;
                end else begin
                    out_y     <= acc_and;
                    out_op    <= s1_op;
                    out_valid <= 1'b1;
                    acc_busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_logic_unit.sv
// Bench for mux_logic_unit: directed 8-bit scenarios plus randomized 32-bit and 1-bit
// instances checked against a plain boolean reference model.
module tb_mux_logic_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic       in_valid, in_ready, in_reduce, in_last, out_valid, out_ready;
    logic [7:0] in_a, in_b, out_y;
    logic [2:0] in_op, out_op;

    logic        w_valid, w_reduce, w_last, w_oready;
    logic [2:0]  w_op;
    logic [31:0] w32_a, w32_b, w32_y;
    logic        w32_ready, w32_ovalid;
    logic [2:0]  w32_op;
    logic [0:0]  w1_a, w1_b, w1_y;
    logic        w1_ready, w1_ovalid;
    logic [2:0]  w1_op;

    mux_logic_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_reduce(in_reduce), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op)
    );

    mux_logic_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w32_ready),
        .in_a(w32_a), .in_b(w32_b), .in_op(w_op), .in_reduce(w_reduce), .in_last(w_last),
        .out_valid(w32_ovalid), .out_ready(w_oready), .out_y(w32_y), .out_op(w32_op)
    );

    mux_logic_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w1_ready),
        .in_a(w1_a), .in_b(w1_b), .in_op(w_op), .in_reduce(w_reduce), .in_last(w_last),
        .out_valid(w1_ovalid), .out_ready(w_oready), .out_y(w1_y), .out_op(w1_op)
    );

    typedef struct {
        logic [63:0] y;
        logic [2:0]  op;
        int          cyc;
    } exp_t;

    exp_t        q8[$];
    exp_t        q32[$];
    exp_t        q1[$];
    logic [63:0] m_acc[3];
    logic        m_busy[3];

    logic       s_acc, s_ov, s_have;
    logic [7:0] s_oy, s_ey;
    logic [2:0] s_oop, s_eop;
    int         s_lat;

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return b;
        endcase
    endfunction

    // Model instance 0 = 8-bit, 1 = 32-bit, 2 = 1-bit; results queued in acceptance order.
    task automatic model_accept(input int d, input logic [2:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic red, input logic last);
        logic [63:0] r, mask;
        exp_t e;
        mask = (d == 0) ? 64'hFF : ((d == 1) ? 64'hFFFF_FFFF : 64'h1);
        r = ref_op(op, a, b) & mask;
        if (red && !last) begin
            m_acc[d]  = m_busy[d] ? (m_acc[d] & r) : r;
            m_busy[d] = 1'b1;
        end else begin
            e.y   = (red && m_busy[d]) ? (m_acc[d] & r) : r;
            e.op  = op;
            e.cyc = cyc;
            m_busy[d] = 1'b0;
            if (d == 0) q8.push_back(e);
            else if (d == 1) q32.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic red, input logic last,
                        input logic ordy);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_op = op;
        in_reduce = red; in_last = last; out_ready = ordy;
        #1;
        s_acc  = v && in_ready;
        s_ov   = out_valid;
        s_oy   = out_y;
        s_oop  = out_op;
        s_have = (q8.size() != 0);
        s_ey = 8'h00; s_eop = 3'd0; s_lat = -1;
        if (s_have) begin
            s_ey  = q8[0].y[7:0];
            s_eop = q8[0].op;
            s_lat = cyc - q8[0].cyc;
        end
        if (s_ov && ordy && s_have) void'(q8.pop_front());
        if (s_acc) model_accept(0, op, {56'b0, a}, {56'b0, b}, red, last);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    task automatic reset_model8();
        q8.delete();
        m_busy[0] = 1'b0;
        m_acc[0]  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_reduce = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        w_valid = 1'b0; w_op = '0; w_reduce = 1'b0; w_last = 1'b0; w_oready = 1'b1;
        w32_a = '0; w32_b = '0; w1_a = '0; w1_b = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rst_hold in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        if (in_ready !== 1'b0 || out_valid !== 1'b0) miscompares++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_op !== 3'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release out_valid=%b out_y=%h out_op=%0d in_ready=%b expected 0 00 0 1",
                     out_valid, out_y, out_op, in_ready);
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] tt[8];
        int k;
        tt = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hCC};
        k = 0;
        for (int j = 0; j < 16; j++) begin
            if (j < 8) step(1'b1, 8'hF0, 8'hCC, 3'(j), 1'b0, 1'b0, 1'b1);
            else idle(1'b1);
            if (j < 8) begin
                vectors++;
                if (!s_acc) begin
                    miscompares++;
                    $display("FAIL tt_accept op=%0d in_ready=0 expected 1", j);
                end
            end
            if (s_ov) begin
                vectors++;
                if (k >= 8 || s_oy !== tt[k] || s_oop !== 3'(k) || s_lat != 2) begin
                    miscompares++;
                    $display("FAIL tt_out idx=%0d got y=%h op=%0d lat=%0d expected y=%h op=%0d lat=2",
                             k, s_oy, s_oop, s_lat, (k < 8) ? tt[k] : 8'hxx, k);
                end
                k++;
            end
        end
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL tt_count got %0d outputs expected 8", k);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] av[4], bv[4];
        logic ordy;
        int nacc, ndel;
        for (int i = 0; i < 4; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
        end
        nacc = 0; ndel = 0;
        for (int c = 0; c < 25; c++) begin
            ordy = (c >= 5);
            if (nacc < 4) step(1'b1, av[nacc], bv[nacc], 3'd0, 1'b0, 1'b0, ordy);
            else idle(ordy);
            if (s_acc) nacc++;
            if (c == 4) begin
                vectors++;
                if (nacc != 2) begin
                    miscompares++;
                    $display("FAIL bp_accepts got %0d accepts while stalled expected 2", nacc);
                end
            end
            if (s_ov) begin
                vectors++;
                if (ndel >= 4 || s_oy !== (av[ndel & 3] & bv[ndel & 3]) || s_oop !== 3'd0) begin
                    miscompares++;
                    $display("FAIL bp_out idx=%0d got y=%h op=%0d expected y=%h op=0",
                             ndel, s_oy, s_oop, av[ndel & 3] & bv[ndel & 3]);
                end
                if (ordy) ndel++;
            end
        end
        vectors++;
        if (ndel != 4 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count got %0d deliveries (%0d pending) expected 4 (0)", ndel, q8.size());
        end
    endtask

    task automatic test_reduction();
        logic [2:0] ops[9];
        logic [7:0] av[9], bv[9], ey[3], got;
        logic [2:0] eo[3], gop;
        int nout;
        ops = '{3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        av  = '{8'h01, 8'h04, 8'hFF, 8'h01, 8'h04, 8'h03, 8'hFF, 8'hFF, 8'hFF};
        bv  = '{8'h02, 8'h00, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ey  = '{8'h00, 8'h00, 8'hFF};
        eo  = '{3'd0, 3'd1, 3'd1};
        for (int p = 0; p < 3; p++) begin
            nout = 0; got = 8'h00; gop = 3'd0;
            for (int j = 0; j < 7; j++) begin
                if (j < 3) step(1'b1, av[3*p+j], bv[3*p+j], ops[3*p+j], 1'b1, 1'(j == 2), 1'b1);
                else idle(1'b1);
                if (s_ov) begin
                    nout++;
                    got = s_oy;
                    gop = s_oop;
                end
            end
            vectors++;
            if (nout != 1 || got !== ey[p] || gop !== eo[p]) begin
                miscompares++;
                $display("FAIL red_pkt%0d got %0d outputs y=%h op=%0d expected 1 output y=%h op=%0d",
                         p, nout, got, gop, ey[p], eo[p]);
            end
        end
    endtask

    task automatic test_abort();
        logic [2:0] ops[4];
        logic [7:0] av[4], bv[4], got[2];
        logic       red[4], lst[4];
        logic [2:0] gop[2];
        int nout;
        ops = '{3'd1, 3'd1, 3'd2, 3'd0};
        av  = '{8'h01, 8'h04, 8'hAA, 8'hFF};
        bv  = '{8'h02, 8'h00, 8'hFF, 8'h0F};
        red = '{1'b1, 1'b1, 1'b0, 1'b1};
        lst = '{1'b0, 1'b0, 1'b0, 1'b1};
        got = '{8'h00, 8'h00};
        gop = '{3'd0, 3'd0};
        nout = 0;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) step(1'b1, av[j], bv[j], ops[j], red[j], lst[j], 1'b1);
            else idle(1'b1);
            if (s_ov) begin
                if (nout < 2) begin
                    got[nout] = s_oy;
                    gop[nout] = s_oop;
                end
                nout++;
            end
        end
        vectors++;
        if (nout != 2 || got[0] !== 8'h55 || gop[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL abort_xor got %0d outputs first y=%h op=%0d expected 2 outputs first y=55 op=2",
                     nout, got[0], gop[0]);
        end
        vectors++;
        if (got[1] !== 8'h0F || gop[1] !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_clear got y=%h op=%0d expected y=0f op=0", got[1], gop[1]);
        end
    endtask

    task automatic test_reset_mid();
        int nout;
        logic [7:0] got;
        // Phase A: one result stalled in the output stage, another waiting behind it.
        step(1'b1, 8'h11, 8'h22, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 8'h44, 3'd7, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        vectors++;
        if (s_ov !== 1'b1 || s_oy !== 8'h22) begin
            miscompares++;
            $display("FAIL rmid_setup got out_valid=%b y=%h expected 1 22", s_ov, s_oy);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_ready_in_reset got %b expected 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model8();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_after got out_valid=%b y=%h in_ready=%b expected 0 00 1",
                     out_valid, out_y, in_ready);
        end
        nout = 0;
        for (int j = 0; j < 5; j++) begin
            idle(1'b1);
            if (s_ov) nout++;
        end
        vectors++;
        if (nout != 0) begin
            miscompares++;
            $display("FAIL rmid_stale got %0d outputs after reset expected 0", nout);
        end
        // Phase B: reset while a reduction packet is being accumulated.
        step(1'b1, 8'h0F, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hF0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model8();
        nout = 0; got = 8'h00;
        for (int j = 0; j < 5; j++) begin
            if (j == 0) step(1'b1, 8'hFF, 8'h3C, 3'd0, 1'b1, 1'b1, 1'b1);
            else idle(1'b1);
            if (s_ov) begin
                nout++;
                got = s_oy;
            end
        end
        vectors++;
        if (nout != 1 || got !== 8'h3C) begin
            miscompares++;
            $display("FAIL rmid_acc got %0d outputs y=%h expected 1 output y=3c", nout, got);
        end
    endtask

    task automatic test_random_widths();
        logic v, rdy;
        exp_t e;
        for (int n = 0; n < 460; n++) begin
            v   = (n < 200) ? 1'b1 : ((n < 440) ? 1'($urandom_range(0, 3) != 0) : 1'b0);
            rdy = (n < 200 || n >= 440) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            @(negedge clk);
            w_valid  = v;
            w_op     = 3'($urandom_range(0, 7));
            w_reduce = 1'($urandom_range(0, 3) == 0);
            w_last   = 1'($urandom_range(0, 2) == 0);
            w32_a    = $urandom;
            w32_b    = $urandom;
            w1_a     = 1'($urandom_range(0, 1));
            w1_b     = 1'($urandom_range(0, 1));
            w_oready = rdy;
            #1;
            if (w32_ovalid) begin
                vectors++;
                if (q32.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd32_spurious y=%h with no result expected", w32_y);
                end else begin
                    e = q32[0];
                    if (w32_y !== e.y[31:0] || w32_op !== e.op || (n < 200 && cyc - e.cyc != 2)) begin
                        miscompares++;
                        $display("FAIL rnd32_out n=%0d got y=%h op=%0d lat=%0d expected y=%h op=%0d",
                                 n, w32_y, w32_op, cyc - e.cyc, e.y[31:0], e.op);
                    end
                    if (rdy) void'(q32.pop_front());
                end
            end
            if (w1_ovalid) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd1_spurious y=%b with no result expected", w1_y);
                end else begin
                    e = q1[0];
                    if (w1_y !== e.y[0:0] || w1_op !== e.op || (n < 200 && cyc - e.cyc != 2)) begin
                        miscompares++;
                        $display("FAIL rnd1_out n=%0d got y=%b op=%0d lat=%0d expected y=%b op=%0d",
                                 n, w1_y, w1_op, cyc - e.cyc, e.y[0], e.op);
                    end
                    if (rdy) void'(q1.pop_front());
                end
            end
            if (v && w32_ready) model_accept(1, w_op, {32'b0, w32_a}, {32'b0, w32_b}, w_reduce, w_last);
            if (v && w1_ready) model_accept(2, w_op, {63'b0, w1_a}, {63'b0, w1_b}, w_reduce, w_last);
        end
        vectors++;
        if (q32.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_drain got %0d/%0d undelivered results expected 0/0", q32.size(), q1.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0;
            m_acc[i]  = '0;
        end
        test_reset();
        test_truth_table();
        test_backpressure();
        test_reduction();
        test_abort();
        test_reset_mid();
        test_random_widths();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
